// File: rtl/multdiv_seq.sv
// multdiv_seq: sequential signed multiplier/divider that sits beside the ALU.
// Multiply uses radix-4 Booth recoding, one recoded digit pair per cycle.
// Divide runs non-restoring division on operand magnitudes, followed by a
// sign fix-up. A one-cycle data_resultRDY pulse marks completion.
// Optional feature macro: MULTDIV_REMAINDER_EN adds the data_remainder port
// (signed remainder for divide, high product word for multiply).
module multdiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
`ifdef MULTDIV_REMAINDER_EN
  ,
  output logic [WIDTH-1:0] data_remainder
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] MULT_LAST = CW'(WIDTH / 2);
  localparam logic [CW-1:0] DIV_LAST  = CW'(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    DIV,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  // Shared datapath registers:
  //   acc   - Booth partial product high part / division partial remainder
  //   lo    - multiplier bits shifting out (and product low bits shifting in)
  //           or dividend bits shifting out (and quotient bits shifting in)
  //   mcand - sign-extended multiplicand B, or zero-extended |B| for divide
  logic [CW-1:0]    count;
  logic [WIDTH+1:0] acc;
  logic [WIDTH-1:0] lo;
  logic             q_m1;
  logic [WIDTH+1:0] mcand;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;

  logic             start;
  logic             mult_last;
  logic             div_last;

  logic [2:0]       booth_sel;
  logic [WIDTH+1:0] booth_addend;
  logic [WIDTH+1:0] booth_sum;
  logic [WIDTH+1:0] div_shift;
  logic [WIDTH+1:0] div_sum;

  logic             mult_ovf;
  logic             quot_neg;
  logic             div_zero;
  logic             div_ovf;
  logic [WIDTH-1:0] div_quot;
`ifdef MULTDIV_REMAINDER_EN
  logic [WIDTH-1:0] rem_mag;
  logic [WIDTH-1:0] div_rem;
`endif

  // Two's complement magnitude; the most-negative value maps to 2^(WIDTH-1)
  // as an unsigned number, which is exactly what the divider needs.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  assign start     = ctrl_MULT | ctrl_DIV;
  assign mult_last = (state == MULT) && (count == MULT_LAST);
  assign div_last  = (state == DIV) && (count == DIV_LAST);

  // State register; reset discards any operation in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and ready pulse; a start pulse restarts from any state, multiply first.
  always_comb begin
    state_next     = state;
    data_resultRDY = 1'b0;
    if (ctrl_MULT) begin
      state_next = MULT;
    end else if (ctrl_DIV) begin
      state_next = DIV;
    end else begin
      case (state)
        IDLE: state_next = IDLE;
        MULT: if (count == MULT_LAST) state_next = DONE;
        DIV:  if (count == DIV_LAST) state_next = DONE;
        DONE: state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
    if (state == DONE) begin
      data_resultRDY = 1'b1;
    end
  end

  // Booth digit selection from two multiplier bits plus the previously shifted-out bit.
  always_comb begin
    booth_sel    = {lo[1:0], q_m1};
    booth_addend = '0;
    case (booth_sel)
      3'b001, 3'b010: booth_addend = mcand;
      3'b011:         booth_addend = mcand << 1;
      3'b100:         booth_addend = -(mcand << 1);
      3'b101, 3'b110: booth_addend = -mcand;
      default:        booth_addend = '0;
    endcase
    booth_sum = acc + booth_addend;
  end

  // Non-restoring step: shift the next dividend bit into the remainder, then
  // subtract the divisor if the remainder is non-negative, otherwise add it.
  always_comb begin
    div_shift = {acc[WIDTH:0], lo[WIDTH-1]};
    div_sum   = acc[WIDTH+1] ? (div_shift + mcand) : (div_shift - mcand);
  end

  // Final result shaping: overflow check, special divide cases and sign fix-up.
  always_comb begin
    mult_ovf = !((&{acc[WIDTH-1:0], lo[WIDTH-1]}) || (~|{acc[WIDTH-1:0], lo[WIDTH-1]}));
    quot_neg = op_a[WIDTH-1] ^ op_b[WIDTH-1];
    div_zero = (op_b == '0);
    div_ovf  = (op_a == MOST_NEG) && (op_b == ALL_ONES);
    div_quot = quot_neg ? -lo : lo;
`ifdef MULTDIV_REMAINDER_EN
    rem_mag  = acc[WIDTH-1:0] + (acc[WIDTH+1] ? mcand[WIDTH-1:0] : '0);
    div_rem  = op_a[WIDTH-1] ? -rem_mag : rem_mag;
`endif
  end

  // Operand latching on start, then one Booth or division step per cycle until the count limit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
      acc   <= '0;
      lo    <= '0;
      q_m1  <= 1'b0;
      mcand <= '0;
      op_a  <= '0;
      op_b  <= '0;
    end else if (ctrl_MULT) begin
      count <= '0;
      acc   <= '0;
      lo    <= data_operandA;
      q_m1  <= 1'b0;
      mcand <= {{2{data_operandB[WIDTH-1]}}, data_operandB};
      op_a  <= data_operandA;
      op_b  <= data_operandB;
    end else if (ctrl_DIV) begin
      count <= '0;
      acc   <= '0;
      lo    <= magnitude(data_operandA);
      q_m1  <= 1'b0;
      mcand <= {2'b00, magnitude(data_operandB)};
      op_a  <= data_operandA;
      op_b  <= data_operandB;
    end else if ((state == MULT) && (count != MULT_LAST)) begin
      acc   <= {{2{booth_sum[WIDTH+1]}}, booth_sum[WIDTH+1:2]};
      lo    <= {booth_sum[1:0], lo[WIDTH-1:2]};
      q_m1  <= lo[1];
      count <= count + CW'(1);
    end else if ((state == DIV) && (count != DIV_LAST)) begin
      acc   <= div_sum;
      lo    <= {lo[WIDTH-2:0], ~div_sum[WIDTH+1]};
      count <= count + CW'(1);
    end
  end

  // Result registers load on the edge entering DONE and hold until the next completion.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_result    <= '0;
      data_exception <= 1'b0;
`ifdef MULTDIV_REMAINDER_EN
      data_remainder <= '0;
`endif
    end else if (!start) begin
      if (mult_last) begin
        data_result    <= lo;
        data_exception <= mult_ovf;
`ifdef MULTDIV_REMAINDER_EN
        data_remainder <= acc[WIDTH-1:0];
`endif
      end else if (div_last) begin
        if (div_zero) begin
          data_result    <= '0;
          data_exception <= 1'b1;
`ifdef MULTDIV_REMAINDER_EN
          data_remainder <= op_a;
`endif
        end else if (div_ovf) begin
          data_result    <= MOST_NEG;
          data_exception <= 1'b1;
`ifdef MULTDIV_REMAINDER_EN
          data_remainder <= '0;
`endif
        end else begin
          data_result    <= div_quot;
          data_exception <= 1'b0;
`ifdef MULTDIV_REMAINDER_EN
          data_remainder <= div_rem;
`endif
        end
      end
    end
  end

endmodule
